mem_bank_be: RTL and testbench
==============================

// Module: mem_bank_be
// PURPOSE
//  Parametrised single-port on-chip memory slave with byte enables and a
//  configurable pipelined read latency (1..4) flagged by oReadDataValid.
//  After reset it optionally zero-fills itself, holding oWaitRequest high.
//  Sits on the system bus behind the interconnect as general scratch/buffer RAM.
// PARAMETERS
//  DATA_WIDTH      32  word width in bits; multiple of 8
//  ADDRESS_WIDTH   4   word address bits; DEPTH = 2**ADDRESS_WIDTH
//  READ_LATENCY    2   cycles from read acceptance to oReadDataValid; 1..4
//  CLEAR_ON_RESET  1   1 = zero-fill all words after reset; 0 = no clear
// PORTS
//  iClk            in   1              clock, all logic on rising edge
//  iReset_n        in   1              synchronous reset, active low
//  iChipSelect_n   in   1              chip select, active low
//  iRead_n         in   1              read strobe, active low
//  iWrite_n        in   1              write strobe, active low
//  iAddress        in   ADDRESS_WIDTH  word address
//  iByteEnable     in   DATA_WIDTH/8   per-byte write enable, active high
//  iData           in   DATA_WIDTH     write data
//  oData           out  DATA_WIDTH     read data, valid when oReadDataValid=1
//  oReadDataValid  out  1              one-cycle pulse per accepted read
//  oWaitRequest    out  1              1 = requests not accepted (clearing)
// BEHAVIOUR
//  Reset (iReset_n=0 at edge): oData=0, oReadDataValid=0, read pipeline
//   flushed, clear counter=0; oWaitRequest=CLEAR_ON_RESET. Array not reset.
//  FSM: CLEAR, READY. Reset -> CLEAR if CLEAR_ON_RESET else READY.
//   CLEAR: each cycle writes 0 to mem[cnt], cnt++; after cnt=DEPTH-1 written
//   -> READY. Takes exactly DEPTH cycles; oWaitRequest=1 throughout.
//   READY: oWaitRequest=0; stays until reset.
//  Accept: write when ~iChipSelect_n & ~iWrite_n & ~oWaitRequest;
//   read when ~iChipSelect_n & ~iRead_n & ~oWaitRequest. Requests while
//   oWaitRequest=1 are ignored (no write, no valid pulse); master must hold.
//  Write: at accept edge, byte b of mem[iAddress] <= iData byte b where
//   iByteEnable[b]=1; other bytes unchanged. iByteEnable=0 -> no change.
//  Read: address captured at accept edge k; oData/oReadDataValid=1 in cycle
//   after edge k+READ_LATENCY-1 (LATENCY=1: cycle right after accept edge).
//   Fully pipelined: one read accepted per cycle, one valid per read, in order.
//  oData holds last returned value while oReadDataValid=0.
//  Simultaneous read+write same cycle: both accepted; read returns data as it
//   was BEFORE that write (read-before-write), same or different address.
//  Address wraps naturally; no out-of-range case. Write on same cycle as a
//   pipelined read in flight to that address: in-flight read unaffected only
//   if already sampled (array read at accept edge).
//  Reset mid-operation: in-flight reads dropped (no valid pulse), clear
//   restarts from address 0; READY->CLEAR if CLEAR_ON_RESET.
// TESTING
//  Reset, DEPTH=16, CLEAR_ON_RESET=1 -> oWaitRequest=1 for exactly 16 cycles,
//   then 0; read every address -> all 0x00000000, one valid pulse each.
//  Write 0xDEADBEEF @3 BE=4'b1111, then BE=4'b0101 data 0x11223344 @3,
//   read @3 -> 0xDE22BE44 on oData with oReadDataValid after READ_LATENCY.
//  Back-to-back reads @0..@15 with READ_LATENCY=3 -> 16 consecutive valid
//   pulses starting 3 cycles after first accept, data in address order.
//  Read+write @5 same cycle (old 0xA5A5A5A5, new 0x5A5A5A5A) -> read returns
//   0xA5A5A5A5; next read @5 returns 0x5A5A5A5A.
//  Write/read asserted during CLEAR -> ignored, no valid pulse, memory stays 0.
//  Reset asserted with 2 reads in flight -> no valid pulses, oData=0,
//   oWaitRequest=1 next cycle, clear restarts at address 0.

Source files
------------

// File: rtl/mem_bank_be_if.sv
// Bus bundle for mem_bank_be: request strobes/address/data from the master,
// read data, valid pulse and wait request back from the memory.
interface mem_bank_be_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4
);
  logic                      iChipSelect_n;
  logic                      iRead_n;
  logic                      iWrite_n;
  logic [ADDRESS_WIDTH-1:0]  iAddress;
  logic [DATA_WIDTH/8-1:0]   iByteEnable;
  logic [DATA_WIDTH-1:0]     iData;
  logic [DATA_WIDTH-1:0]     oData;
  logic                      oReadDataValid;
  logic                      oWaitRequest;

  modport master (
    output iChipSelect_n, iRead_n, iWrite_n, iAddress, iByteEnable, iData,
    input  oData, oReadDataValid, oWaitRequest
  );

  modport slave (
    input  iChipSelect_n, iRead_n, iWrite_n, iAddress, iByteEnable, iData,
    output oData, oReadDataValid, oWaitRequest
  );
endinterface

// File: rtl/mem_bank_be.sv
// Single-port scratch RAM with byte-enable writes, pipelined reads of 1..4
// cycles latency, and an optional zero-fill sweep after reset.
module mem_bank_be #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int READ_LATENCY   = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          iClk,
  input  logic          iReset_n,
  mem_bank_be_if.slave  bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int RL    = READ_LATENCY;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ADDRESS_WIDTH-1:0]  r_cnt;
  logic [ADDRESS_WIDTH-1:0]  w_cnt_nxt;
  logic                      w_wait;
  logic                      w_clr_we;
  logic                      w_wr_acc;
  logic                      w_rd_acc;

  logic [DATA_WIDTH-1:0]     r_mem [DEPTH];

  logic [RL-1:0]             r_vld_p;
  logic [DATA_WIDTH-1:0]     r_dat_p [RL];
  logic [RL-1:0]             w_vld_in;
  logic [DATA_WIDTH-1:0]     w_dat_in [RL];

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wait      = 1'b1;
    w_clr_we    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we  = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == ADDRESS_WIDTH'(DEPTH - 1)) w_state_nxt = S_READY;
      end
      S_READY: w_wait = 1'b0;
      default: w_state_nxt = S_READY;
    endcase
  end

  // Requests are only taken outside reset and once the clear sweep is done.
  assign w_wr_acc = iReset_n & ~bus.iChipSelect_n & ~bus.iWrite_n & ~w_wait;
  assign w_rd_acc = iReset_n & ~bus.iChipSelect_n & ~bus.iRead_n  & ~w_wait;

  always_ff @(posedge iClk) begin
    if (iReset_n && w_clr_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.iByteEnable[b]) r_mem[bus.iAddress][8*b +: 8] <= bus.iData[8*b +: 8];
      end
    end
  end

  // Stage 0 samples the array at the accept edge, so a same-edge write is
  // not visible (read-before-write); the last stage is the output register.
  always_comb begin
    w_vld_in    = '0;
    w_vld_in[0] = w_rd_acc;
    w_dat_in[0] = r_mem[bus.iAddress];
    for (int i = 1; i < RL; i++) begin
      w_vld_in[i] = r_vld_p[i-1];
      w_dat_in[i] = r_dat_p[i-1];
    end
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_vld_p         <= '0;
      r_dat_p[RL-1]   <= '0;
    end else begin
      r_vld_p <= w_vld_in;
      for (int i = 0; i < RL; i++) begin
        if ((i < RL - 1) || w_vld_in[i]) r_dat_p[i] <= w_dat_in[i];
      end
    end
  end

  assign bus.oData          = r_dat_p[RL-1];
  assign bus.oReadDataValid = r_vld_p[RL-1];
  assign bus.oWaitRequest   = w_wait;
endmodule

// File: tb/tb_mem_bank_be.sv
// Directed and randomized bench for mem_bank_be (READ_LATENCY=3, clear on reset),
// compared every cycle against a word-array/read-queue model of the memory.
module tb_mem_bank_be;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bank_be_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  mem_bank_be #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
  ) dut (
    .iClk(clk),
    .iReset_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
  } rd_t;

  rd_t         q[$];
  logic [31:0] model [DEPTH];
  int          clear_left = 0;
  logic [31:0] m_odata    = '0;
  int          edge_n     = 0;
  int          checks     = 0;
  int          errors     = 0;
  int          vld_seen   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit cs, input bit rd, input bit wr, input logic [3:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    bus.iChipSelect_n = ~cs;
    bus.iRead_n       = ~rd;
    bus.iWrite_n      = ~wr;
    bus.iAddress      = a;
    bus.iByteEnable   = be;
    bus.iData         = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  // One clock edge: apply the memory rules to the model, then compare outputs.
  task automatic tick();
    bit          m_wait, rd, wr, expv;
    logic [3:0]  a, be;
    logic [31:0] d;
    rd_t         e;
    m_wait = (clear_left > 0);
    rd = rst_n && !bus.iChipSelect_n && !bus.iRead_n  && !m_wait;
    wr = rst_n && !bus.iChipSelect_n && !bus.iWrite_n && !m_wait;
    a  = bus.iAddress;
    be = bus.iByteEnable;
    d  = bus.iData;
    @(posedge clk);
    edge_n++;
    if (!rst_n) begin
      q.delete();
      clear_left = DEPTH;
      m_odata    = '0;
    end else begin
      if (rd) begin
        e.due = edge_n + LAT - 1;
        e.d   = model[a];
        q.push_back(e);
      end
      if (wr) begin
        for (int b = 0; b < 4; b++) if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
      end
      if (clear_left > 0) begin
        model[DEPTH - clear_left] = '0;
        clear_left--;
      end
    end
    #1;
    expv = (q.size() > 0) && (q[0].due == edge_n);
    if (expv) begin
      e = q.pop_front();
      m_odata = e.d;
    end
    check("valid",   {31'b0, bus.oReadDataValid}, {31'b0, expv});
    check("rdata",   bus.oData, m_odata);
    check("waitreq", {31'b0, bus.oWaitRequest}, {31'b0, clear_left > 0});
    if (bus.oReadDataValid === 1'b1) vld_seen++;
  endtask

  task automatic idle_until_valid(output logic [31:0] d, output int n);
    d = '0;
    n = 99;
    for (int i = 1; i <= 10; i++) begin
      idle();
      tick();
      if (bus.oReadDataValid === 1'b1) begin
        d = bus.oData;
        n = i;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    int          n;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    idle();
    repeat (3) tick();
    check("rst_wait", {31'b0, bus.oWaitRequest}, 32'd1);
    check("rst_odata", bus.oData, 32'h0);

    // Requests during the clear sweep must be ignored.
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("clr_wait_hi", {31'b0, bus.oWaitRequest}, 32'd1);
      drive(1'b1, 1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'hF, $urandom);
      tick();
    end
    check("clr_wait_lo", {31'b0, bus.oWaitRequest}, 32'd0);

    vld_seen = 0;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, 1'b1, 1'b0, 4'(a), 4'h0, 32'h0);
      tick();
    end
    idle();
    repeat (LAT + 2) tick();
    check("b2b_count", 32'(vld_seen), 32'd16);

    drive(1'b1, 1'b0, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF);
    tick();
    drive(1'b1, 1'b0, 1'b1, 4'd3, 4'b0101, 32'h11223344);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd3, 4'h0, 32'h0);
    tick();
    idle_until_valid(d, n);
    check("be_latency", 32'(n), 32'(LAT - 1));
    check("be_merge", d, 32'hDE22BE44);

    drive(1'b1, 1'b0, 1'b1, 4'd5, 4'hF, 32'hA5A5A5A5);
    tick();
    drive(1'b1, 1'b1, 1'b1, 4'd5, 4'hF, 32'h5A5A5A5A);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd5, 4'h0, 32'h0);
    tick();
    idle_until_valid(d, n);
    check("rbw_old", d, 32'hA5A5A5A5);
    idle_until_valid(d, n);
    check("rbw_new", d, 32'h5A5A5A5A);
    check("rbw_new_lat", 32'(n), 32'd1);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
      tick();
    end
    idle();
    repeat (LAT + 1) tick();

    // Reset with two reads in flight drops both.
    drive(1'b1, 1'b1, 1'b0, 4'd1, 4'h0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd2, 4'h0, 32'h0);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", {31'b0, bus.oReadDataValid}, 32'd0);
    check("mid_rst_odata", bus.oData, 32'h0);
    check("mid_rst_wait", {31'b0, bus.oWaitRequest}, 32'd1);
    rst_n = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0;
    while (bus.oWaitRequest === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("reclear_len", 32'(n), 32'd16);

    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, 1'b1, 1'b0, 4'(a), 4'h0, 32'h0);
      tick();
    end
    idle();
    repeat (LAT + 2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
